// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-memory loader.
// master drives s_data/s_valid; slave (the loader) returns s_ready.
interface imem_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream. Four bytes
// are packed little-endian into one word and written at base, base+4, ...
// Ports: clk, rst_n (sync, active-low), start, base_addr, num_words,
//   s (stream slave: s_data, s_valid, s_ready), mem_we, mem_addr,
//   mem_wdata, busy, done, checksum (only with IMEM_LOADER_CHECKSUM_EN).
// All outputs are registered from the next state.
module imem_loader #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_words,
    imem_loader_if.slave     s,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic             done,
    output logic [31:0]      checksum
`else
    output logic             done
`endif
);

    typedef enum logic [1:0] {
        IDLE, COLLECT, WRITE, DONE
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [23:0]      word_q;
    logic [31:0]      mem_addr_q, mem_wdata_q;
    logic             s_ready_q, s_ready_d;
    logic             mem_we_q, mem_we_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept, last_byte;

    assign accept    = (state_q == COLLECT) && s.s_valid;
    assign last_byte = accept && (idx_q == 2'd3);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            mem_we_q  <= mem_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_words == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (last_byte) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // cnt_q still counts the word being written
                state_d = (cnt_q == CNT_W'(1)) ? DONE : COLLECT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they register in step
    always_comb begin
        s_ready_d = (state_d == COLLECT);
        mem_we_d  = (state_d == WRITE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
    assign checksum = sum_q;
`endif

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            if (state_q == IDLE && start) begin
                addr_q <= base_addr & ~32'd3;
                cnt_q  <= num_words;
                idx_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q  <= '0;
`endif
            end
            if (accept) begin
                idx_q <= idx_q + 2'd1;
                unique case (idx_q)
                    2'd0:    word_q[7:0]   <= s.s_data;
                    2'd1:    word_q[15:8]  <= s.s_data;
                    2'd2:    word_q[23:16] <= s.s_data;
                    default: ;
                endcase
            end
            // 4th byte goes straight into the write register
            if (last_byte) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= {s.s_data, word_q};
            end
            if (state_q == WRITE) begin
                addr_q <= addr_q + 32'd4;
                cnt_q  <= cnt_q - CNT_W'(1);
                idx_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q  <= sum_q + mem_wdata_q;
`endif
            end
        end
    end

    assign s.s_ready = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a word-level model predicts every
// write and done pulse; directed loads pin the model with literal values.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        busy, done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    imem_loader_if s_if();

    imem_loader #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .s         (s_if),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .done      (done),
        .checksum  (checksum)
`else
        .done      (done)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int exp_done = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_sum = '0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    logic [7:0]  bytes_a[0:15];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_bytes(input logic [63:0] v);
        for (int i = 0; i < 8; i++) bytes_a[i] = v[8*i +: 8];
    endtask

    // Word-level model: what a load of n words from base must write
    function automatic void model_load(input logic [31:0] base, input int n);
        logic [31:0] a;
        logic [31:0] w;
        a = base & ~32'd3;
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            w = {bytes_a[4*i+3], bytes_a[4*i+2], bytes_a[4*i+1], bytes_a[4*i]};
            exp_addr.push_back(a + 32'(4 * i));
            exp_data.push_back(w);
            exp_sum += w;
        end
        exp_done++;
    endfunction

    // Compare process
    always @(negedge clk) begin
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
            chk("we_busy", {31'd0, busy}, 32'd1);
            chk("we_sready", {31'd0, s_if.s_ready}, 32'd0);
            if (exp_addr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %h data %h, none expected",
                         mem_addr, mem_wdata);
            end else begin
                chk("wr_addr", mem_addr, exp_addr.pop_front());
                chk("wr_data", mem_wdata, exp_data.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_busy", {31'd0, busy}, 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk("done_sum", checksum, exp_sum);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] n);
        base_addr = b;
        num_words = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit acc;
        n = 0;
        s_if.s_data = b;
        s_if.s_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = s_if.s_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_byte: byte %h not accepted in %0d cycles", b, n);
        end
    endtask

    task automatic gap();
        s_if.s_valid = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string name);
        int c0;
        int n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < 200) begin
            tick();
            n++;
        end
        if (done_cnt == c0) begin
            tests++;
            fails++;
            $display("FAIL %s: no done within %0d cycles", name, n);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        int d0;
        s_if.s_valid = 1'b0;
        s_if.s_data = '0;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sready", {31'd0, s_if.s_ready}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("rst_sum", checksum, 32'd0);
`endif

        // Basic load, start on first cycle after release
        rst_n = 1'b1;
        set_bytes(64'h00A0_0093_0050_0013);
        model_load(32'h0, 2);
        l0 = log_addr.size();
        do_start(32'h0, 16'd2);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_sready", {31'd0, s_if.s_ready}, 32'd1);
        for (int i = 0; i < 8; i++) send_byte(bytes_a[i]);
        s_if.s_valid = 1'b0;
        wait_done("basic");
        chk("basic_nwr", 32'(log_addr.size() - l0), 32'd2);
        chk("basic_a0", log_addr[l0], 32'h0);
        chk("basic_d0", log_data[l0], 32'h00500013);
        chk("basic_a1", log_addr[l0+1], 32'h4);
        chk("basic_d1", log_data[l0+1], 32'h00A00093);
        chk("basic_word_gap", 32'(log_cyc[l0+1] - log_cyc[l0]), 32'd5);
        chk("basic_done_lat", 32'(done_cyc - log_cyc[l0+1]), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("basic_sum", checksum, 32'h00F000A6);
`endif
        chk("basic_idle", {31'd0, busy}, 32'd0);

        // Zero count
        model_load(32'h40, 0);
        l0 = log_addr.size();
        do_start(32'h40, 16'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("zero_sum_clr", checksum, 32'd0);
`endif
        tick();
        chk("zero_done_off", {31'd0, done}, 32'd0);
        chk("zero_busy_off", {31'd0, busy}, 32'd0);
        chk("zero_nwr", 32'(log_addr.size() - l0), 32'd0);

        // Misaligned base
        set_bytes(64'h0000_0000_4433_2211);
        model_load(32'h103, 1);
        l0 = log_addr.size();
        do_start(32'h103, 16'd1);
        for (int i = 0; i < 4; i++) send_byte(bytes_a[i]);
        s_if.s_valid = 1'b0;
        wait_done("misalign");
        chk("mis_addr", log_addr[l0], 32'h100);
        chk("mis_data", log_data[l0], 32'h44332211);

        // Backpressure, byte held over WRITE, start while busy
        set_bytes(64'h8877_6655_0403_0201);
        model_load(32'h2000, 2);
        l0 = log_addr.size();
        do_start(32'h2000, 16'd2);
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes_a[i]);
            gap();
        end
        send_byte(bytes_a[3]);
        s_if.s_data = bytes_a[4];
        s_if.s_valid = 1'b1;
        chk("bp_wr_we", {31'd0, mem_we}, 32'd1);
        chk("bp_wr_sready", {31'd0, s_if.s_ready}, 32'd0);
        send_byte(bytes_a[4]);
        s_if.s_valid = 1'b0;
        do_start(32'hDEAD_0000, 16'd5);
        for (int i = 5; i < 8; i++) begin
            send_byte(bytes_a[i]);
            gap();
        end
        wait_done("backpressure");
        chk("bp_d0", log_data[l0], 32'h04030201);
        chk("bp_a1", log_addr[l0+1], 32'h2004);
        chk("bp_d1", log_data[l0+1], 32'h88776655);
        repeat (3) tick();
        chk("bp_start_ignored", {31'd0, busy}, 32'd0);

        // Abort after two bytes
        set_bytes(64'h0000_0000_DDCC_BBAA);
        model_load(32'h300, 1);
        do_start(32'h300, 16'd1);
        send_byte(bytes_a[0]);
        send_byte(bytes_a[1]);
        s_if.s_valid = 1'b0;
        rst_n = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        exp_done--;
        l0 = log_addr.size();
        d0 = done_cnt;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("abort_nwr", 32'(log_addr.size() - l0), 32'd0);
        chk("abort_ndone", 32'(done_cnt - d0), 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_addr", mem_addr, 32'd0);

        model_load(32'h300, 1);
        do_start(32'h300, 16'd1);
        for (int i = 0; i < 4; i++) send_byte(bytes_a[i]);
        s_if.s_valid = 1'b0;
        wait_done("reload");
        chk("reload_addr", log_addr[l0], 32'h300);
        chk("reload_data", log_data[l0], 32'hDDCCBBAA);

        repeat (2) tick();
        chk("pending_writes", 32'(exp_addr.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(exp_done));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills instruction memory before the core runs. It accepts a byte stream over a valid/ready handshake and assembles each group of four bytes into a little-endian 32-bit instruction word. Each word is written into instruction memory at consecutive word-aligned byte addresses (base, base+4, base+8, …). It is the write-side counterpart to the instruction memory's combinational `address` → `instruction` read port.

## Interface
- `CNT_W`, default 16: width of the word-count input.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE.
- `base_addr`  in  32  byte address of the first word; bits [1:0] forced to 0.
- `num_words`  in  CNT_W  number of words to load; 0 is legal.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  32  write byte address; meaningful only when `mem_we`=1.
- `mem_wdata`  out  32  write data; meaningful only when `mem_we`=1.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the load completes.
- `checksum`  out  32  present only with `IMEM_LOADER_CHECKSUM_EN`.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- **IDLE:**
  - On `start`, latch `base_addr & ~3` into the address register and `num_words` into the remaining-word counter.
  - Clear the byte index (0..3).
  - Go to COLLECT, or to DONE if `num_words`=0.
- **COLLECT:**
  - `s_ready`=1.
  - A byte transfers when `s_valid && s_ready`; byte k of the word goes to bits [8k+7:8k], so the first byte is the LSB.
  - The 4th accepted byte moves the block to WRITE.
- **WRITE:**
  - `s_ready`=0, `mem_we`=1, `mem_addr`=current address, `mem_wdata`=assembled word.
  - Then the address increments by 4 (32-bit wrap, no error), the counter decrements, and the byte index clears.
  - Next state is COLLECT if words remain, otherwise DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored.
- Bytes presented outside COLLECT are not consumed; the source must hold them.
- `mem_addr` and `mem_wdata` hold their last values when `mem_we`=0.

## Timing
- **Reset values:**
  - state IDLE;
  - `s_ready`, `mem_we`, `busy`, `done` = 0;
  - `mem_addr`, `mem_wdata`, `checksum` = 0.
- **Reset mid-operation:**
  - The load is aborted and any partial word is discarded.
  - No `mem_we` is issued in the cycle reset is asserted or after it.
  - No `done` pulse is generated.
- **Start latency:**
  - `start` at cycle t gives `busy`=1 and `s_ready`=1 at t+1.
  - With `num_words`=0, `done` pulses at t+1 and `busy` falls at t+2.
- **Write latency:** 4th byte accepted at cycle t → `mem_we`=1 at t+1 → `s_ready`=1 again at t+2 if words remain.
- **Completion:** after the last write at cycle t, `done`=1 at t+1 and the block is in IDLE at t+2.
- **Throughput:** at most one word per 5 cycles under continuous `s_valid`.
- Gaps in `s_valid` stall COLLECT indefinitely with no timeout.
- All outputs are registered.

## Configuration
- **`IMEM_LOADER_CHECKSUM_EN` defined:**
  - `checksum` is a 32-bit wrapping sum of every `mem_wdata` written during the current load.
  - Cleared to 0 when `start` is accepted; updated in the WRITE cycle.
  - Final and stable from the `done` cycle until the next accepted `start`.
- **Undefined:** the `checksum` port and its logic are absent; all other behaviour is identical.

## Test plan
- **Reset:** assert `rst_n`=0 for 2 cycles → all outputs 0 and `s_ready`=0; a `start` pulse on the first cycle after release is accepted.
- **Basic load:**
  - Stimulus: `base_addr`=0x0, `num_words`=2, bytes 13 00 50 00 93 00 A0 00 with continuous valid.
  - Writes: (0x0, 0x00500013), then (0x4, 0x00A00093).
  - `done` pulses exactly one cycle after the second `mem_we`, and each write occupies one cycle.
- **Zero count and misalignment:**
  - `num_words`=0 → `done` one cycle after `start`, no `mem_we`.
  - `base_addr`=0x103, `num_words`=1 → the write goes to 0x100.
- **Backpressure:**
  - Stimulus: `s_valid` toggled 1/0 between bytes, plus a byte presented during the WRITE cycle.
  - The WRITE-cycle byte is not consumed (`s_ready`=0) and is accepted the following cycle.
  - Words assemble correctly; `start` pulsed while busy is ignored.
- **Abort:** `rst_n`=0 after 2 bytes of the first word → no `mem_we`, no `done`; a subsequent full load writes correct data from byte 0.
- **Checksum (macro defined):** basic load above → `checksum`=0x00F000A6 at `done`; a second `start` clears it to 0.
